// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter: FSM state
// encoding, default region bases, starvation limit and counter widths.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  localparam logic [31:0] DEF_TEXT_BASE = 32'h0040_0000;
  localparam logic [31:0] DEF_DATA_BASE = 32'h1001_0000;

  // Consecutive arbitration losses after which a pending fetch is forced through.
  localparam int unsigned           LOSS_W       = 2;
  localparam logic [LOSS_W-1:0]     STARVE_LIMIT = 2'd2;

  // Wait-state counter width (WAIT_STATES is limited to 0..15).
  localparam int unsigned WAIT_W = 4;

endpackage

// File: rtl/mem_addr_xlate.sv
// Byte address -> RAM word index translation with alignment and range check.
//   addr_i        : byte address of the winning requester
//   base_i        : byte base of that requester's region
//   word_idx_c_o  : (addr_i - base_i) >> 2, truncated to the RAM address width
//   err_c_o       : misaligned, or word index outside the RAM (incl. wrap below base)
module mem_addr_xlate #(
  parameter  int unsigned MEMORY_DEPTH = 1024,
  localparam int unsigned AW           = $clog2(MEMORY_DEPTH)
) (
  input  logic [31:0]   addr_i,
  input  logic [31:0]   base_i,
  output logic [AW-1:0] word_idx_c_o,
  output logic          err_c_o
);

  logic [31:0] offset;
  logic [31:0] word_idx;

  // Unsigned subtract: an address below base wraps to a huge index and fails the range check.
  assign offset       = addr_i - base_i;
  assign word_idx     = offset >> 2;
  assign word_idx_c_o = AW'(word_idx);
  assign err_c_o      = (addr_i[1:0] != 2'b00) || (word_idx >= 32'(MEMORY_DEPTH));

endmodule

// File: rtl/memory_port_arbiter.sv
// Arbitrates instruction fetches and data loads/stores onto one single-port RAM.
// One transfer at a time: IDLE (arbitrate + latch) -> ACCESS (WAIT_STATES+1
// cycles) -> RESP (one-cycle ack). Data has priority unless fetch has lost
// STARVE_LIMIT consecutive arbitrations.
//   clk, reset             : clock, asynchronous active-high reset
//   if_req/if_addr         : fetch request (level) and byte address
//   if_rdata/if_ack        : fetched word and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata : data request, store flag, byte address, store data
//   d_rdata/d_ack          : load data and one-cycle completion pulse
//   err                    : with an ack, the access was misaligned or out of range
//   mem_addr/mem_we/mem_wdata/mem_rdata : RAM word port (read is combinational)
//   busy                   : transfer in progress
module memory_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEMORY_DEPTH = 1024,
  parameter int unsigned WAIT_STATES  = 1,
  parameter logic [31:0] TEXT_BASE    = DEF_TEXT_BASE,
  parameter logic [31:0] DATA_BASE    = DEF_DATA_BASE
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            if_req,
  input  logic [31:0]                     if_addr,
  output logic [31:0]                     if_rdata,
  output logic                            if_ack,
  input  logic                            d_req,
  input  logic                            d_we,
  input  logic [31:0]                     d_addr,
  input  logic [31:0]                     d_wdata,
  output logic [31:0]                     d_rdata,
  output logic                            d_ack,
  output logic                            err,
  output logic [$clog2(MEMORY_DEPTH)-1:0] mem_addr,
  output logic                            mem_we,
  output logic [31:0]                     mem_wdata,
  input  logic [31:0]                     mem_rdata,
  output logic                            busy
);

  localparam int unsigned AW = $clog2(MEMORY_DEPTH);

  arb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic              fetch_q, fetch_d;
  logic              we_q, we_d;
  logic              acc_err_q, acc_err_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              err_q, err_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;

  logic              fetch_wins_c;
  logic [31:0]       win_addr_c;
  logic [31:0]       win_base_c;
  logic [AW-1:0]     x_idx_c;
  logic              x_err_c;
  logic [31:0]       resp_data_c;

  // Data has priority unless fetch has been starved.
  assign fetch_wins_c = if_req && (!d_req || (loss_q >= STARVE_LIMIT));
  assign win_addr_c   = fetch_wins_c ? if_addr : d_addr;
  assign win_base_c   = fetch_wins_c ? TEXT_BASE : DATA_BASE;
  assign resp_data_c  = acc_err_q ? 32'h0 : mem_rdata;

  mem_addr_xlate #(
    .MEMORY_DEPTH(MEMORY_DEPTH)
  ) u_xlate (
    .addr_i       (win_addr_c),
    .base_i       (win_base_c),
    .word_idx_c_o (x_idx_c),
    .err_c_o      (x_err_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    loss_d     = loss_q;
    fetch_d    = fetch_q;
    we_d       = we_q;
    acc_err_d  = acc_err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mem_we_d   = 1'b0;
    busy_d     = 1'b0;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    err_d      = 1'b0;
    if_rdata_d = 32'h0;
    d_rdata_d  = 32'h0;

    case (state_q)
      ST_IDLE: begin
        if (if_req || d_req) begin
          state_d   = ST_ACCESS;
          fetch_d   = fetch_wins_c;
          we_d      = !fetch_wins_c && d_we;
          acc_err_d = x_err_c;
          addr_d    = x_idx_c;
          wdata_d   = d_wdata;
          cnt_d     = WAIT_W'(WAIT_STATES);
          // Losses count only while fetch keeps asking; any fetch grant clears them.
          if (fetch_wins_c) begin
            loss_d = '0;
          end else if (if_req) begin
            loss_d = (loss_q < STARVE_LIMIT) ? loss_q + LOSS_W'(1) : loss_q;
          end else begin
            loss_d = '0;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          err_d   = acc_err_q;
          if (fetch_q) begin
            if_ack_d   = 1'b1;
            if_rdata_d = resp_data_c;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = resp_data_c;
          end
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Write strobe lines up with the last ACCESS cycle of a valid store.
    mem_we_d = (state_d == ST_ACCESS) && (cnt_d == '0) && we_d && !acc_err_d;
    busy_d   = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      loss_q     <= '0;
      fetch_q    <= 1'b0;
      we_q       <= 1'b0;
      acc_err_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      loss_q     <= loss_d;
      fetch_q    <= fetch_d;
      we_q       <= we_d;
      acc_err_q  <= acc_err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_ack     = d_ack_q;
  assign err       = err_q;
  assign mem_addr  = addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench for memory_port_arbiter: directed vector table, multi-cycle
// corner sequences, randomized traffic against a transaction-level model, and a
// zero-wait-state instance for back-to-back fetch throughput.
module tb_memory_port_arbiter;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WS    = 1;
  localparam logic [31:0] TBASE = 32'h0040_0000;
  localparam logic [31:0] DBASE = 32'h1001_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        if_req, if_ack, d_req, d_we, d_ack, err, mem_we, busy;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;

  logic        if_req0, if_ack0, d_req0, d_we0, d_ack0, err0, mem_we0, busy0;
  logic [31:0] if_addr0, if_rdata0, d_addr0, d_wdata0, d_rdata0, mem_wdata0, mem_rdata0;
  logic [9:0]  mem_addr0;

  int n_checks = 0;
  int n_fail   = 0;

  memory_port_arbiter #(.MEMORY_DEPTH(DEPTH), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  memory_port_arbiter #(.MEMORY_DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .if_req(if_req0), .if_addr(if_addr0), .if_rdata(if_rdata0), .if_ack(if_ack0),
    .d_req(d_req0), .d_we(d_we0), .d_addr(d_addr0), .d_wdata(d_wdata0),
    .d_rdata(d_rdata0), .d_ack(d_ack0), .err(err0),
    .mem_addr(mem_addr0), .mem_we(mem_we0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata0), .busy(busy0)
  );

  // Environment RAM for the main instance; the WS=0 instance reads a fixed pattern.
  logic [31:0] ram [DEPTH];
  logic        ram_load;

  function automatic logic [31:0] init_word(input int i);
    return (i == 2) ? 32'h2008_0005 : (32'hC0DE_0000 ^ 32'(i));
  endfunction

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < int'(DEPTH); i++) ram[i] <= init_word(i);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata  = ram[mem_addr];
  assign mem_rdata0 = 32'hA500_0000 | 32'(mem_addr0);

  // Reference memory image and translation rule used by the model.
  logic [31:0] ref_mem [DEPTH];

  function automatic void ref_xlate(input logic [31:0] a, input logic [31:0] base,
                                    output int unsigned idx, output bit bad);
    logic [31:0] w;
    w   = (a - base) / 32'd4;
    bad = (a % 32'd4 != 32'd0) || (w >= 32'(DEPTH));
    idx = bad ? 0 : int'(w);
  endfunction

  function automatic logic [31:0] rand_addr(input logic [31:0] base);
    int unsigned r;
    logic [31:0] a;
    r = $urandom_range(0, 15);
    a = base + 32'($urandom_range(0, 1031)) * 32'd4;
    if (r == 0)      a = a + 32'($urandom_range(1, 3));
    else if (r == 1) a = base - 32'd4 * 32'($urandom_range(1, 4));
    return a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          fetch;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    bit          exp_wr;
    logic [9:0]  exp_widx;
  } vec_t;

  function automatic vec_t mk(input bit f, input bit w, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input bit e, input bit wr, input logic [9:0] wi);
    vec_t v;
    v.fetch = f; v.we = w; v.addr = a; v.wdata = wd;
    v.exp_rdata = rd; v.exp_err = e; v.exp_wr = wr; v.exp_widx = wi;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [12];
    vec_t        v;
    bit          got, seen, side;
    int          lat, nwe, n, nack, idx0, diff;
    logic [9:0]  we_idx;
    logic [5:0]  ord;
    // random-phase state
    bit          f_pend, dp, d_w, xv, xf, xerr, xwr, e_if, e_d, e_we, e_busy, bad;
    logic [31:0] f_a, d_a, d_wd, xrd, xwd, a, b;
    logic [9:0]  xidx;
    int          x_grant, x_ack, free_at, losses;
    int unsigned idx;

    vecs[0]  = mk(1, 0, 32'h0040_0008, 32'h0,         32'h2008_0005, 0, 0, 10'd0);
    vecs[1]  = mk(0, 1, 32'h1001_0010, 32'hDEAD_BEEF, 32'hC0DE_0004, 0, 1, 10'd4);
    vecs[2]  = mk(0, 0, 32'h1001_0010, 32'h0,         32'hDEAD_BEEF, 0, 0, 10'd0);
    vecs[3]  = mk(1, 0, 32'h0040_0010, 32'h0,         32'hDEAD_BEEF, 0, 0, 10'd0);
    vecs[4]  = mk(0, 1, 32'h1001_0002, 32'hCAFE_F00D, 32'h0,         1, 0, 10'd0);
    vecs[5]  = mk(0, 0, 32'h0FFF_FFFC, 32'h0,         32'h0,         1, 0, 10'd0);
    vecs[6]  = mk(0, 0, 32'h1001_0FFC, 32'h0,         32'hC0DE_03FF, 0, 0, 10'd0);
    vecs[7]  = mk(0, 0, 32'h1001_1000, 32'h0,         32'h0,         1, 0, 10'd0);
    vecs[8]  = mk(1, 0, 32'h0040_0001, 32'h0,         32'h0,         1, 0, 10'd0);
    vecs[9]  = mk(1, 0, 32'h003F_FFFC, 32'h0,         32'h0,         1, 0, 10'd0);
    vecs[10] = mk(0, 0, 32'h1001_0000, 32'h0,         32'hC0DE_0000, 0, 0, 10'd0);
    vecs[11] = mk(0, 1, 32'h1001_0FFC, 32'h0BAD_1DEA, 32'hC0DE_03FF, 0, 1, 10'd1023);

    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_word(i);

    reset = 1'b1; ram_load = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    if_req0 = 0; if_addr0 = 0; d_req0 = 0; d_we0 = 0; d_addr0 = 0; d_wdata0 = 0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_ack_err", 32'({if_ack, d_ack, err}), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_rdata", if_rdata | d_rdata | mem_wdata, 32'd0);
    ram_load = 1'b0;
    reset = 1'b0;
    tick();

    // Directed single transfers.
    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      if_req = v.fetch; if_addr = v.addr;
      d_req = !v.fetch; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
      got = 0; lat = 0; nwe = 0; we_idx = 0;
      for (int k = 1; k <= 12 && !got; k++) begin
        tick();
        if (mem_we) begin
          nwe++; we_idx = mem_addr;
          chk($sformatf("vec%0d_wdata", i), mem_wdata, v.wdata);
        end
        if (if_ack || d_ack) begin
          got = 1; lat = k;
          chk($sformatf("vec%0d_ackport", i), 32'({if_ack, d_ack}), v.fetch ? 32'd2 : 32'd1);
          chk($sformatf("vec%0d_rdata", i), v.fetch ? if_rdata : d_rdata, v.exp_rdata);
          chk($sformatf("vec%0d_other_rdata", i), v.fetch ? d_rdata : if_rdata, 32'd0);
          chk($sformatf("vec%0d_err", i), 32'(err), 32'(v.exp_err));
          if_req = 0; d_req = 0;
        end
      end
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(2 + WS));
      chk($sformatf("vec%0d_we_pulses", i), 32'(nwe), 32'(v.exp_wr));
      if (v.exp_wr) begin
        chk($sformatf("vec%0d_we_addr", i), 32'(we_idx), 32'(v.exp_widx));
        ref_mem[v.exp_widx] = v.wdata;
      end
      tick();
    end

    // Both requesters held: data, data, fetch, data, data, fetch.
    if_req = 1; if_addr = TBASE; d_req = 1; d_we = 0; d_addr = DBASE;
    n = 0; ord = '0;
    for (int k = 0; k < 40 && n < 6; k++) begin
      tick();
      if (if_ack)     begin ord[n] = 1'b1; n++; end
      else if (d_ack) begin ord[n] = 1'b0; n++; end
    end
    if_req = 0; d_req = 0;
    chk("order_count", 32'(n), 32'd6);
    chk("order_seq", 32'(ord), 32'b100100);
    tick();

    // Request dropped after one cycle is still completed.
    d_req = 1; d_we = 0; d_addr = DBASE + 32'h8;
    tick();
    d_req = 0;
    got = 0; lat = 0;
    for (int k = 2; k <= 12 && !got; k++) begin
      tick();
      if (d_ack) begin
        got = 1; lat = k;
        chk("drop_rdata", d_rdata, 32'h2008_0005);
      end
    end
    chk("drop_latency", 32'(lat), 32'(2 + WS));
    tick();

    // Reset during the write cycle of a store.
    d_req = 1; d_we = 1; d_addr = DBASE + 32'h20; d_wdata = 32'h1234_5678;
    tick(); tick();
    chk("rstmid_we_before", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    chk("rstmid_we_now", 32'(mem_we), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    d_req = 0; d_we = 0;
    tick(); tick();
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (d_ack || if_ack || mem_we) seen = 1;
    end
    chk("rstmid_no_ack", 32'(seen), 32'd0);
    chk("rstmid_ram", ram[8], init_word(8));

    // Randomized traffic against the transaction-level model.
    f_pend = 0; dp = 0; d_w = 0; xv = 0; xf = 0; xerr = 0; xwr = 0;
    f_a = TBASE; d_a = DBASE; d_wd = 0; xrd = 0; xwd = 0; xidx = 0;
    x_grant = 0; x_ack = 0; free_at = 0; losses = 0;
    for (int t = 0; t < 600; t++) begin
      e_if   = xv && xf && (t == x_ack);
      e_d    = xv && !xf && (t == x_ack);
      e_we   = xv && xwr && (t == x_ack - 1);
      e_busy = xv && (t > x_grant) && (t <= x_ack);
      chk("rnd_if_ack", 32'(if_ack), 32'(e_if));
      chk("rnd_d_ack", 32'(d_ack), 32'(e_d));
      chk("rnd_err", 32'(err), 32'((e_if || e_d) && xerr));
      chk("rnd_if_rdata", if_rdata, e_if ? xrd : 32'h0);
      chk("rnd_d_rdata", d_rdata, e_d ? xrd : 32'h0);
      chk("rnd_mem_we", 32'(mem_we), 32'(e_we));
      chk("rnd_busy", 32'(busy), 32'(e_busy));
      if (e_we) begin
        chk("rnd_we_addr", 32'(mem_addr), 32'(xidx));
        chk("rnd_we_data", mem_wdata, xwd);
      end
      if (e_if) f_pend = 0;
      if (e_d)  dp = 0;
      if (e_if || e_d) xv = 0;
      if (!f_pend && t < 560 && $urandom_range(0, 2) == 0) begin
        f_pend = 1; f_a = rand_addr(TBASE);
      end
      if (!dp && t < 560 && $urandom_range(0, 2) == 0) begin
        dp = 1; d_w = 1'($urandom_range(0, 1)); d_a = rand_addr(DBASE); d_wd = $urandom;
      end
      if_req = f_pend; if_addr = f_a;
      d_req = dp; d_we = d_w; d_addr = d_a; d_wdata = d_wd;
      if (!xv && t >= free_at && (f_pend || dp)) begin
        xf = f_pend && (!dp || losses >= 2);
        if (xf)          losses = 0;
        else if (f_pend) losses++;
        else             losses = 0;
        a = xf ? f_a : d_a;
        b = xf ? TBASE : DBASE;
        ref_xlate(a, b, idx, bad);
        xerr = bad;
        xwr  = !xf && d_w && !bad;
        xidx = 10'(idx);
        xwd  = d_wd;
        xrd  = bad ? 32'h0 : ref_mem[idx];
        if (xwr) ref_mem[idx] = d_wd;
        x_grant = t; x_ack = t + 2 + int'(WS); free_at = x_ack + 1; xv = 1;
      end
      tick();
    end
    if_req = 0; d_req = 0;
    tick(); tick();
    diff = 0;
    for (int i = 0; i < int'(DEPTH); i++) if (ram[i] !== ref_mem[i]) diff++;
    chk("rnd_ram_image", 32'(diff), 32'd0);

    // Zero-wait-state instance: held fetch acks every third cycle.
    if_req0 = 1; if_addr0 = TBASE; idx0 = 0; nack = 0; side = 0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      chk("ws0_if_ack", 32'(if_ack0), 32'(t % 3 == 2));
      if (if_ack0) begin
        chk("ws0_rdata", if_rdata0, 32'hA500_0000 | 32'(idx0));
        idx0++; nack++;
        if_addr0 = TBASE + 32'(idx0) * 32'd4;
      end
      if (d_ack0 || mem_we0 || err0) side = 1;
    end
    if_req0 = 0;
    chk("ws0_ack_count", 32'(nack), 32'd10);
    chk("ws0_side_effects", 32'(side), 32'd0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
